// File: rtl/fetch_queue.sv
// Fetch-to-decode packet queue: buffers fetch packets, issues one valid lane per cycle in order.
// Latency: a packet accepted at edge N is presented after edge N; no in_* to out_* bypass.
// Backpressure: in_ready = !full (independent of out_ready); out_ready stalls the head lane.

package cpu_params;
    localparam int IF_WIDTH = 1;
endpackage

module fetch_queue #(
    parameter int DEPTH    = 8,
    parameter int IF_WIDTH = cpu_params::IF_WIDTH,
    localparam int PKT_W   = IF_WIDTH * 65 + IF_WIDTH + 32,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [PKT_W-1:0]  in_packet,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic              out_predict_taken,
    output logic [31:0]       out_predict_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Field order is MSB first and must match the producer's packing.
    typedef struct packed {
        logic [IF_WIDTH-1:0][31:0] inst;
        logic [IF_WIDTH-1:0]       predict_taken;
        logic [IF_WIDTH-1:0][31:0] predict_target;
        logic [31:0]               pc;
        logic [IF_WIDTH-1:0]       valid;
    } fetch_packet_t;

    fetch_packet_t       pkt_q  [DEPTH];
    logic [IF_WIDTH-1:0] pend_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    fetch_packet_t       in_pkt;
    fetch_packet_t       head_pkt;
    logic [IF_WIDTH-1:0] head_pend;
    logic [IF_WIDTH-1:0] sel_oh;
    logic [IF_WIDTH-1:0] pend_after;
    logic                full;
    logic                empty;
    logic                do_enq;
    logic                do_deq;
    logic                retire;

    assign in_pkt     = in_packet;
    assign head_pkt   = pkt_q[head_q];
    assign head_pend  = pend_q[head_q];

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign out_valid  = !empty && !flush;
    assign count      = count_q;

    // Lowest pending lane is isolated with x & -x; clearing it retires the entry when nothing is left.
    assign sel_oh     = head_pend & (~head_pend + IF_WIDTH'(1));
    assign pend_after = head_pend & ~sel_oh;

    // Packets with no valid lane complete the handshake but are not stored.
    assign do_enq     = in_valid && in_ready && (|in_pkt.valid);
    assign do_deq     = out_valid && out_ready;
    assign retire     = do_deq && (pend_after == '0);

    // Present the lowest pending lane of the head entry; scanning downward leaves the lowest hit.
    always_comb begin
        out_inst           = head_pkt.inst[0];
        out_predict_taken  = head_pkt.predict_taken[0];
        out_predict_target = head_pkt.predict_target[0];
        out_pc             = head_pkt.pc;
        for (int i = IF_WIDTH - 1; i >= 0; i--) begin
            if (head_pend[i]) begin
                out_inst           = head_pkt.inst[i];
                out_predict_taken  = head_pkt.predict_taken[i];
                out_predict_target = head_pkt.predict_target[i];
                out_pc             = head_pkt.pc + 32'(4 * i);
            end
        end
    end

    // Pointer and occupancy next state; a simultaneous enqueue and retire leaves count unchanged.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (retire) begin
            head_d = head_q + PTR_W'(1);
        end
        if (do_enq) begin
            tail_d = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_enq) - CNT_W'(retire);
    end

    // State update: reset beats flush, flush beats any enqueue/dequeue in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                pkt_q[e]  <= '0;
                pend_q[e] <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                pend_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // head and tail only alias when empty or full, where one of these cannot fire.
            if (do_deq) begin
                pend_q[head_q] <= pend_after;
            end
            if (do_enq) begin
                pkt_q[tail_q]  <= in_pkt;
                pend_q[tail_q] <= in_pkt.valid;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue with a two-lane build and a lane-level scoreboard.
// Latency: expectations are committed at the edge that accepts a packet.
// Backpressure: bench follows the DUT's in_ready when deciding what was accepted.

module tb_fetch_queue;

    localparam int W     = 2;
    localparam int D     = 8;
    localparam int PKT_W = W * 65 + W + 32;

    typedef struct packed {
        logic [W-1:0][31:0] inst;
        logic [W-1:0]       predict_taken;
        logic [W-1:0][31:0] predict_target;
        logic [31:0]        pc;
        logic [W-1:0]       valid;
    } pkt_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } instr_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [PKT_W-1:0] in_packet;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    logic             out_predict_taken;
    logic [31:0]      out_predict_target;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       count;

    fetch_queue #(.DEPTH(D), .IF_WIDTH(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .in_packet          (in_packet),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_inst           (out_inst),
        .out_pc             (out_pc),
        .out_predict_taken  (out_predict_taken),
        .out_predict_target (out_predict_target),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .count              (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: instructions still to be issued, and lanes remaining per stored packet.
    instr_t exp_q[$];
    int     lanes_q[$];

    logic cap_clear = 1'b0;
    logic cap_push  = 1'b0;
    pkt_t cap_pkt   = '0;

    logic [31:0] fix_i1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model input capture mid-cycle, when inputs and in_ready are settled.
    always @(negedge clk) begin
        pkt_t p;
        p         = in_packet;
        cap_clear = rst || flush;
        cap_push  = !rst && !flush && in_valid && in_ready && (p.valid != '0);
        cap_pkt   = p;
    end

    // Model commit at the accepting edge: every valid lane becomes one expected instruction.
    always @(posedge clk) begin
        if (cap_clear) begin
            exp_q.delete();
            lanes_q.delete();
        end else if (cap_push) begin
            int n;
            n = 0;
            for (int l = 0; l < W; l++) begin
                if (cap_pkt.valid[l]) begin
                    instr_t e;
                    e.inst   = cap_pkt.inst[l];
                    e.pc     = cap_pkt.pc + 32'(4 * l);
                    e.taken  = cap_pkt.predict_taken[l];
                    e.target = cap_pkt.predict_target[l];
                    exp_q.push_back(e);
                    n++;
                end
            end
            lanes_q.push_back(n);
        end
    end

    // Monitor: compare status against the model, then pop on every consumed output.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(count), 32'(lanes_q.size()));
            chk("in_ready", 32'(in_ready), 32'(lanes_q.size() < D));
            chk("out_valid", 32'(out_valid), 32'(!flush && lanes_q.size() > 0));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                instr_t e;
                e = exp_q.pop_front();
                chk("out_inst", out_inst, e.inst);
                chk("out_pc", out_pc, e.pc);
                chk("out_taken", 32'(out_predict_taken), 32'(e.taken));
                chk("out_target", out_predict_target, e.target);
                lanes_q[0] = lanes_q[0] - 1;
                if (lanes_q[0] == 0) void'(lanes_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [1:0] m, input logic [31:0] pc,
                       input logic ordy, input logic fl, output logic acc);
        pkt_t p;
        for (int l = 0; l < W; l++) begin
            p.inst[l]           = $urandom;
            p.predict_taken[l]  = 1'($urandom_range(1));
            p.predict_target[l] = $urandom & 32'hFFFF_FFFC;
        end
        if (fix_i1 != '0) p.inst[1] = fix_i1;
        p.pc      = pc;
        p.valid   = m;
        in_packet = p;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = v && in_ready && !fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot_lane();
        return ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        logic acc;
        int   sent;
        int   cyc_n;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_packet = '1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_target", out_predict_target, 32'd0);

        // Fill to full with out_ready low, try one extra push, then drain in order.
        for (int k = 0; k < D; k++) cyc(1'b1, 2'b01, 32'h1000 + 32'(4 * k), 1'b0, 1'b0, acc);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'(D));
        cyc(1'b1, 2'b01, 32'h2000, 1'b0, 1'b0, acc);
        chk("full_no_accept", 32'(acc), 32'd0);
        for (int k = 0; k < D + 2; k++) cyc(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, acc);
        chk("drained_count", 32'(count), 32'd0);

        // Lane skipping and an all-invalid packet.
        fix_i1 = 32'h0000_0013;
        cyc(1'b1, 2'b10, 32'h1ECE_B000, 1'b0, 1'b0, acc);
        fix_i1 = '0;
        cyc(1'b1, 2'b00, 32'h3000, 1'b0, 1'b0, acc);
        chk("invalid_pkt_count", 32'(count), 32'd1);
        chk("lane1_pc", out_pc, 32'h1ECE_B004);
        chk("lane1_inst", out_inst, 32'h0000_0013);
        cyc(1'b1, 2'b11, 32'h4000, 1'b1, 1'b0, acc);
        for (int k = 0; k < 4; k++) cyc(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, acc);
        chk("lanes_drained", 32'(exp_q.size()), 32'd0);

        // Steady state: three entries, then enqueue and dequeue together.
        for (int k = 0; k < 3; k++) cyc(1'b1, onehot_lane(), 32'h5000 + 32'(8 * k), 1'b0, 1'b0, acc);
        for (int k = 0; k < 5; k++) cyc(1'b1, onehot_lane(), 32'h6000 + 32'(8 * k), 1'b1, 1'b0, acc);
        chk("steady_count", 32'(count), 32'd3);

        // Flush with a concurrent push and pop.
        for (int k = 0; k < 2; k++) cyc(1'b1, 2'b11, 32'h7000 + 32'(8 * k), 1'b0, 1'b0, acc);
        chk("pre_flush_count", 32'(count), 32'd5);
        cyc(1'b1, 2'b11, 32'h8000, 1'b1, 1'b1, acc);
        chk("post_flush_count", 32'(count), 32'd0);
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, acc);

        // Random traffic across many pointer wraps.
        sent  = 0;
        cyc_n = 0;
        while (sent < 40 && cyc_n < 1000) begin
            cyc(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(1)), 1'b0, acc);
            if (acc) sent++;
            cyc_n++;
        end
        chk("random_budget", 32'(sent >= 40), 32'd1);
        for (int k = 0; k < 2 * D * W + 4; k++) cyc(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, acc);
        chk("final_empty", 32'(exp_q.size()), 32'd0);
        chk("final_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
